// File: rtl/color_distance_unit.sv
//==============================================================================
// Module   : color_distance_unit
// Purpose  : Manhattan distance from one RGB sample to six calibrated references,
//            followed by the C1..C5 comparison tree used by the min-index decoder.
// Option   : COLOR_REJECT_EN adds the MAX_DIST rejection flag on o_invalid.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module color_distance_unit #(
   parameter int W = 8
`ifdef COLOR_REJECT_EN
   , parameter int MAX_DIST = 96
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_cal_we,
   input  logic [2:0]   i_cal_idx,
   input  logic [W-1:0] i_cal_r,
   input  logic [W-1:0] i_cal_g,
   input  logic [W-1:0] i_cal_b,
   input  logic         i_start,
   input  logic [W-1:0] i_sample_r,
   input  logic [W-1:0] i_sample_g,
   input  logic [W-1:0] i_sample_b,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_c1,
   output logic         o_c2,
   output logic         o_c3,
   output logic         o_c4,
   output logic         o_c5,
   output logic [W+1:0] o_min_dist,
   output logic         o_invalid
);

   localparam int DW = W + 2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CALC = 3'd1,
      S_CMP1 = 3'd2,
      S_CMP2 = 3'd3,
      S_CMP3 = 3'd4
   } state_t;

   state_t         r_state, w_state_next;
   logic           w_accept, w_busy;
   logic [2:0]     r_idx;
   logic [W-1:0]   r_s_r, r_s_g, r_s_b;
   logic [W-1:0]   r_ref_r [6];
   logic [W-1:0]   r_ref_g [6];
   logic [W-1:0]   r_ref_b [6];
   logic [DW-1:0]  r_dist [6];
   logic [W-1:0]   w_ref_r, w_ref_g, w_ref_b;
   logic [DW-1:0]  w_dist;
   logic           r_p1, r_p2, r_p3, r_p4;
   logic [DW-1:0]  r_min01, r_min23, r_min45, r_min03;
   logic           w_c4, w_c5;
   logic [DW-1:0]  w_min_next;
   logic           r_c1, r_c2, r_c3, r_c4, r_c5, r_done, r_invalid;
   logic [DW-1:0]  r_min_dist;

   function automatic logic [DW-1:0] absdiff(input logic [W-1:0] a, input logic [W-1:0] b);
      return (a > b) ? DW'(a - b) : DW'(b - a);
   endfunction

   // Busy stretches over the done cycle so a start there is not taken.
   assign w_busy = (r_state != S_IDLE) || r_done;

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: if (i_start && !r_done) begin
            w_accept     = 1'b1;
            w_state_next = S_CALC;
         end
         S_CALC: if (r_idx == 3'd5) w_state_next = S_CMP1;
         S_CMP1: w_state_next = S_CMP2;
         S_CMP2: w_state_next = S_CMP3;
         S_CMP3: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_ref_r = '0;
      w_ref_g = '0;
      w_ref_b = '0;
      if (r_idx < 3'd6) begin
         w_ref_r = r_ref_r[r_idx];
         w_ref_g = r_ref_g[r_idx];
         w_ref_b = r_ref_b[r_idx];
      end
      w_dist = absdiff(r_s_r, w_ref_r) + absdiff(r_s_g, w_ref_g) + absdiff(r_s_b, w_ref_b);
   end

   assign w_c4       = r_min23 < r_min01;
   assign w_c5       = r_min45 < r_min03;
   assign w_min_next = w_c5 ? r_min45 : r_min03;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_s_r      <= '0;
         r_s_g      <= '0;
         r_s_b      <= '0;
         for (int i = 0; i < 6; i++) begin
            r_ref_r[i] <= '0;
            r_ref_g[i] <= '0;
            r_ref_b[i] <= '0;
            r_dist[i]  <= '0;
         end
         {r_p1, r_p2, r_p3, r_p4} <= '0;
         r_min01    <= '0;
         r_min23    <= '0;
         r_min45    <= '0;
         r_min03    <= '0;
         {r_c1, r_c2, r_c3, r_c4, r_c5} <= '0;
         r_min_dist <= '0;
         r_invalid  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= 1'b0;
         if (i_cal_we && !w_busy && (i_cal_idx < 3'd6)) begin
            r_ref_r[i_cal_idx] <= i_cal_r;
            r_ref_g[i_cal_idx] <= i_cal_g;
            r_ref_b[i_cal_idx] <= i_cal_b;
         end
         if (w_accept) begin
            r_s_r <= i_sample_r;
            r_s_g <= i_sample_g;
            r_s_b <= i_sample_b;
            r_idx <= '0;
         end
         case (r_state)
            S_CALC: begin
               if (r_idx < 3'd6) r_dist[r_idx] <= w_dist;
               r_idx <= r_idx + 3'd1;
            end
            S_CMP1: begin
               r_p1    <= r_dist[1] < r_dist[0];
               r_p2    <= r_dist[3] < r_dist[2];
               r_p3    <= r_dist[5] < r_dist[4];
               r_min01 <= (r_dist[1] < r_dist[0]) ? r_dist[1] : r_dist[0];
               r_min23 <= (r_dist[3] < r_dist[2]) ? r_dist[3] : r_dist[2];
               r_min45 <= (r_dist[5] < r_dist[4]) ? r_dist[5] : r_dist[4];
            end
            S_CMP2: begin
               r_p4    <= w_c4;
               r_min03 <= w_c4 ? r_min23 : r_min01;
            end
            S_CMP3: begin
               // Outputs are published together so they only change at done.
               r_c1       <= r_p1;
               r_c2       <= r_p2;
               r_c3       <= r_p3;
               r_c4       <= r_p4;
               r_c5       <= w_c5;
               r_min_dist <= w_min_next;
`ifdef COLOR_REJECT_EN
               r_invalid  <= (w_min_next > DW'(MAX_DIST));
`else
               r_invalid  <= 1'b0;
`endif
               r_done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_busy     = w_busy;
   assign o_done     = r_done;
   assign o_c1       = r_c1;
   assign o_c2       = r_c2;
   assign o_c3       = r_c3;
   assign o_c4       = r_c4;
   assign o_c5       = r_c5;
   assign o_min_dist = r_min_dist;
   assign o_invalid  = r_invalid;

endmodule

`default_nettype wire

// File: tb/tb_color_distance_unit.sv
//==============================================================================
// Module   : tb_color_distance_unit
// Purpose  : Scoreboard bench for color_distance_unit (W=8), directed + random.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_color_distance_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_cal_we = 1'b0;
   logic [2:0] i_cal_idx = '0;
   logic [7:0] i_cal_r = '0, i_cal_g = '0, i_cal_b = '0;
   logic       i_start = 1'b0;
   logic [7:0] i_sample_r = '0, i_sample_g = '0, i_sample_b = '0;
   logic       o_busy, o_done, o_c1, o_c2, o_c3, o_c4, o_c5, o_invalid;
   logic [9:0] o_min_dist;

   color_distance_unit dut (
      .clk(clk), .rst(rst),
      .i_cal_we(i_cal_we), .i_cal_idx(i_cal_idx),
      .i_cal_r(i_cal_r), .i_cal_g(i_cal_g), .i_cal_b(i_cal_b),
      .i_start(i_start),
      .i_sample_r(i_sample_r), .i_sample_g(i_sample_g), .i_sample_b(i_sample_b),
      .o_busy(o_busy), .o_done(o_done),
      .o_c1(o_c1), .o_c2(o_c2), .o_c3(o_c3), .o_c4(o_c4), .o_c5(o_c5),
      .o_min_dist(o_min_dist), .o_invalid(o_invalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] c;
      int         md;
      logic       inv;
      int         acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   m_ref_r[6], m_ref_g[6], m_ref_b[6];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Reference model: distances and comparison tree straight from their definitions.
   function automatic exp_t model(input int r, input int g, input int b);
      int   d[6];
      int   mn;
      exp_t e;
      for (int i = 0; i < 6; i++)
         d[i] = iabs(r - m_ref_r[i]) + iabs(g - m_ref_g[i]) + iabs(b - m_ref_b[i]);
      e.c[0] = d[1] < d[0];
      e.c[1] = d[3] < d[2];
      e.c[2] = d[5] < d[4];
      e.c[3] = imin(d[2], d[3]) < imin(d[0], d[1]);
      e.c[4] = imin(d[4], d[5]) < imin(imin(d[0], d[1]), imin(d[2], d[3]));
      mn = d[0];
      for (int i = 1; i < 6; i++) mn = imin(mn, d[i]);
      e.md = mn;
`ifdef COLOR_REJECT_EN
      e.inv = (mn > 96);
`else
      e.inv = 1'b0;
`endif
      e.acc = 0;
      return e;
   endfunction

   // Monitor: every done pulse is matched against the oldest expectation.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (prev_done) check("busy_after_done", int'(o_busy), 0);
      prev_done <= o_done;
      if (!rst && o_done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            check("C1", int'(o_c1), int'(e.c[0]));
            check("C2", int'(o_c2), int'(e.c[1]));
            check("C3", int'(o_c3), int'(e.c[2]));
            check("C4", int'(o_c4), int'(e.c[3]));
            check("C5", int'(o_c5), int'(e.c[4]));
            check("min_dist", int'(o_min_dist), e.md);
            check("invalid", int'(o_invalid), int'(e.inv));
            check("latency", cyc - e.acc, 9);
            check("busy_at_done", int'(o_busy), 1);
         end
      end
   end

   task automatic wait_idle();
      int guard = 0;
      while ((o_busy || o_done) && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) check("idle_timeout", 0, 1);
   endtask

   task automatic cal(input int idx, input int r, input int g, input int b);
      i_cal_we = 1'b1;
      i_cal_idx = 3'(idx);
      i_cal_r = 8'(r); i_cal_g = 8'(g); i_cal_b = 8'(b);
      @(negedge clk);
      i_cal_we = 1'b0;
      if (idx < 6) begin
         m_ref_r[idx] = r; m_ref_g[idx] = g; m_ref_b[idx] = b;
      end
   endtask

   // Starts one run from idle; optionally writes a reference on the same edge.
   task automatic run(input int r, input int g, input int b, input bit use_exp, input exp_t ex,
                      input bit do_cal, input int cidx, input int cr, input int cg, input int cb);
      exp_t e;
      wait_idle();
      i_start = 1'b1;
      i_sample_r = 8'(r); i_sample_g = 8'(g); i_sample_b = 8'(b);
      if (do_cal) begin
         i_cal_we = 1'b1; i_cal_idx = 3'(cidx);
         i_cal_r = 8'(cr); i_cal_g = 8'(cg); i_cal_b = 8'(cb);
         if (cidx < 6) begin
            m_ref_r[cidx] = cr; m_ref_g[cidx] = cg; m_ref_b[cidx] = cb;
         end
      end
      e = use_exp ? ex : model(r, g, b);
      @(negedge clk);
      i_start = 1'b0;
      i_cal_we = 1'b0;
      i_sample_r = 8'($urandom); i_sample_g = 8'($urandom); i_sample_b = 8'($urandom);
      e.acc = cyc;
      q.push_back(e);
   endtask

   function automatic exp_t mk(input logic [4:0] c51, input int md, input logic inv);
      exp_t e;
      e.c = {c51[0], c51[1], c51[2], c51[3], c51[4]};
      e.md = md;
      e.inv = inv;
      e.acc = 0;
      return e;
   endfunction

   task automatic load_std_refs();
      cal(0, 255, 0, 0);   cal(1, 0, 255, 0);     cal(2, 0, 0, 255);
      cal(3, 255, 255, 0); cal(4, 255, 128, 0);   cal(5, 255, 255, 255);
   endtask

   exp_t dummy;

   initial begin
      for (int i = 0; i < 6; i++) begin
         m_ref_r[i] = 0; m_ref_g[i] = 0; m_ref_b[i] = 0;
      end
      dummy = mk(5'b0, 0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", int'(o_busy), 0);
      check("rst_done", int'(o_done), 0);
      check("rst_C", int'({o_c1, o_c2, o_c3, o_c4, o_c5}), 0);
      check("rst_min_dist", int'(o_min_dist), 0);
      check("rst_invalid", int'(o_invalid), 0);

      // Reset in the middle of a run: no done, outputs and references cleared.
      load_std_refs();
      run(128, 128, 128, 1'b1, mk(5'b01011, 255, 1'b0), 1'b0, 0, 0, 0, 0);
      void'(q.pop_back());
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         m_ref_r[i] = 0; m_ref_g[i] = 0; m_ref_b[i] = 0;
      end
      check("midrst_busy", int'(o_busy), 0);
      check("midrst_min_dist", int'(o_min_dist), 0);
      repeat (12) @(negedge clk);
      run(10, 20, 30, 1'b1, mk(5'b00000, 60, 1'b0), 1'b0, 0, 0, 0, 0);

      // Directed samples against the standard reference set.
      wait_idle();
      load_std_refs();
      run(250, 5, 5, 1'b1, mk(5'b01000, 15, 1'b0), 1'b0, 0, 0, 0, 0);
      run(0, 0, 250, 1'b1, mk(5'b00110, 5, 1'b0), 1'b0, 0, 0, 0, 0);
      run(255, 130, 0, 1'b1, mk(5'b01011, 2, 1'b0), 1'b0, 0, 0, 0, 0);
`ifdef COLOR_REJECT_EN
      run(128, 128, 128, 1'b1, mk(5'b01011, 255, 1'b1), 1'b0, 0, 0, 0, 0);
`else
      run(128, 128, 128, 1'b1, mk(5'b01011, 255, 1'b0), 1'b0, 0, 0, 0, 0);
`endif

      // Randomized runs with idle, same-edge and mid-run (ignored) calibration writes.
      for (int n = 0; n < 30; n++) begin
         wait_idle();
         if ($urandom_range(0, 2) == 0)
            cal($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255));
         run($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
             1'b0, dummy, ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(0, 8)) @(negedge clk);
            i_cal_we = 1'b1;
            i_cal_idx = 3'($urandom_range(0, 5));
            i_cal_r = 8'($urandom); i_cal_g = 8'($urandom); i_cal_b = 8'($urandom);
            @(negedge clk);
            i_cal_we = 1'b0;
         end
      end

      // Start held high: runs every 11 edges, sample captured only on the accept edge.
      begin
         int next_acc;
         int runs;
         exp_t e;
         wait_idle();
         i_start = 1'b1;
         next_acc = cyc + 1;
         runs = 0;
         while (runs < 4) begin
            i_sample_r = 8'($urandom); i_sample_g = 8'($urandom); i_sample_b = 8'($urandom);
            if (cyc + 1 == next_acc) begin
               e = model(int'(i_sample_r), int'(i_sample_g), int'(i_sample_b));
               e.acc = next_acc;
               q.push_back(e);
               next_acc += 11;
               runs++;
            end
            @(negedge clk);
         end
         i_start = 1'b0;
      end

      wait_idle();
      repeat (3) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
